// File: rtl/debug_slave_pkg.sv
// Shared definitions for the CPU debug slave: default widths, command payload
// type and the one-hot action decoder.
package debug_slave_pkg;

    localparam int unsigned DEF_IR_WIDTH = 2;
    localparam int unsigned DEF_SR_WIDTH = 38;
    // Upper bound on IR width supported by the action decoder.
    localparam int unsigned MAX_IR_WIDTH = 8;
    localparam int unsigned MAX_ACTIONS  = 2 ** MAX_IR_WIDTH;

    // Command payload at default widths; parametrised users declare the same
    // {ir, data} layout at their own widths.
    typedef struct packed {
        logic [DEF_IR_WIDTH-1:0] ir;
        logic [DEF_SR_WIDTH-1:0] data;
    } cmd_t;

    // One-hot decode of an instruction index; callers truncate to 2**IR_WIDTH.
    function automatic logic [MAX_ACTIONS-1:0] onehot_decode(input logic [MAX_IR_WIDTH-1:0] idx);
        logic [MAX_ACTIONS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/debug_cmd_fifo.sv
// Synchronous show-ahead FIFO with occupancy count.
// Ports: clk, reset (sync, active-high), push/wdata, pop, rdata (head),
//        count (0..DEPTH), full_c/empty_c (combinational flags).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module debug_cmd_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full_c,
    output logic                     empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign pop_ok  = pop & ~empty_c;
    assign push_ok = push & (~full_c | pop_ok);
    assign rdata   = mem[rd_ptr];

    // Storage, pointers (natural power-of-two wrap) and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/debug_slave_cmd_bridge.sv
// System-clock half of the CPU debug slave. Synchronises and edge-detects the
// TCK-domain update-DR/update-IR strobes, captures sr/ir_in, pulses one-hot
// take_action / ir_update and queues each DR command for the controller.
// Ports: clk, reset (sync, active-high); vs_udr, vs_uir (async strobes);
//        ir_in, sr (quasi-static captures); jdo, ir_latched, take_action,
//        ir_update (capture outputs); cmd_valid/cmd_ready/cmd_ir/cmd_data
//        (show-ahead queue head); fifo_count; overflow (sticky) / overflow_clr.
module debug_slave_cmd_bridge
    import debug_slave_pkg::*;
#(
    parameter int unsigned IR_WIDTH    = DEF_IR_WIDTH,
    parameter int unsigned SR_WIDTH    = DEF_SR_WIDTH,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    input  logic [IR_WIDTH-1:0]           ir_in,
    input  logic [SR_WIDTH-1:0]           sr,
    output logic [SR_WIDTH-1:0]           jdo,
    output logic [IR_WIDTH-1:0]           ir_latched,
    output logic [(2**IR_WIDTH)-1:0]      take_action,
    output logic                          ir_update,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [IR_WIDTH-1:0]           cmd_ir,
    output logic [SR_WIDTH-1:0]           cmd_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          overflow_clr
);

    localparam int unsigned NUM_ACT    = 2 ** IR_WIDTH;
    localparam int unsigned CMD_W      = IR_WIDTH + SR_WIDTH;
    localparam int unsigned ARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned ARM_W      = $clog2(ARM_CYCLES + 1);

    typedef struct packed {
        logic [IR_WIDTH-1:0] ir;
        logic [SR_WIDTH-1:0] data;
    } bridge_cmd_t;

    logic [1:0]       strobe;
    logic [1:0]       rise;
    logic [ARM_W-1:0] arm_cnt;
    logic             armed;
    logic             udr_evt;
    logic             uir_evt;
    logic             push_q;
    bridge_cmd_t      push_cmd;
    bridge_cmd_t      head;
    logic             full_c;
    logic             empty_c;
    logic             pop;

    assign strobe = {vs_uir, vs_udr};

    // Per-strobe synchroniser chain plus previous-value register for rise detect.
    for (genvar g = 0; g < 2; g++) begin : g_sync
        logic [SYNC_STAGES-1:0] chain;
        logic                   prev;

        always_ff @(posedge clk) begin
            if (reset) begin
                chain <= '0;
                prev  <= 1'b0;
            end else begin
                chain <= {chain[SYNC_STAGES-2:0], strobe[g]};
                prev  <= chain[SYNC_STAGES-1];
            end
        end

        assign rise[g] = chain[SYNC_STAGES-1] & ~prev;
    end

    // Mask edges until the chains and prev registers reflect real input levels,
    // so a strobe held high across reset never looks like a fresh rise.
    assign armed = (arm_cnt == ARM_W'(ARM_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            arm_cnt <= '0;
        end else if (!armed) begin
            arm_cnt <= arm_cnt + ARM_W'(1);
        end
    end

    assign udr_evt = rise[0] & armed;
    assign uir_evt = rise[1] & armed;

    // Capture registers and action pulses; the queue push lands one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            jdo         <= '0;
            ir_latched  <= '0;
            take_action <= '0;
            ir_update   <= 1'b0;
            push_q      <= 1'b0;
            push_cmd    <= '0;
        end else begin
            take_action <= udr_evt ? NUM_ACT'(onehot_decode(MAX_IR_WIDTH'(ir_in))) : '0;
            ir_update   <= uir_evt;
            push_q      <= udr_evt;
            if (udr_evt || uir_evt) begin
                ir_latched <= ir_in;
            end
            if (udr_evt) begin
                jdo      <= sr;
                push_cmd <= '{ir: ir_in, data: sr};
            end
        end
    end

    assign pop = cmd_valid & cmd_ready;

    debug_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_q),
        .wdata   (push_cmd),
        .pop     (pop),
        .rdata   (head),
        .count   (fifo_count),
        .full_c  (full_c),
        .empty_c (empty_c)
    );

    assign cmd_valid = ~empty_c;
    assign cmd_ir    = head.ir;
    assign cmd_data  = head.data;

    // Sticky drop flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (push_q && full_c && !pop) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_debug_slave_cmd_bridge.sv
// Directed bench for debug_slave_cmd_bridge at default parameters.
module tb_debug_slave_cmd_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        vs_udr;
    logic        vs_uir;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic [37:0] jdo;
    logic [1:0]  ir_latched;
    logic [3:0]  take_action;
    logic        ir_update;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_ir;
    logic [37:0] cmd_data;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        overflow_clr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    debug_slave_cmd_bridge dut (
        .clk          (clk),
        .reset        (reset),
        .vs_udr       (vs_udr),
        .vs_uir       (vs_uir),
        .ir_in        (ir_in),
        .sr           (sr),
        .jdo          (jdo),
        .ir_latched   (ir_latched),
        .take_action  (take_action),
        .ir_update    (ir_update),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_ir       (cmd_ir),
        .cmd_data     (cmd_data),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise strobes and advance to just after edge k+2 (capture edge).
    task automatic strobe_start(input logic udr, input logic uir, input logic [1:0] ir, input logic [37:0] d);
        ir_in  = ir;
        sr     = d;
        vs_udr = udr;
        vs_uir = uir;
        repeat (3) tick();
    endtask

    task automatic strobe_end();
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        repeat (4) tick();
    endtask

    task automatic udr_event(input logic [1:0] ir, input logic [37:0] d);
        strobe_start(1'b1, 1'b0, ir, d);
        tick();
        strobe_end();
    endtask

    task automatic drain_check(input string tag, input logic [37:0] exp);
        check({tag, "_valid"}, cmd_valid, 1);
        check({tag, "_data"}, cmd_data, exp);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ta_seen;
        logic       iu_seen;
        logic [2:0] cnt_seen;

        reset = 1'b1; vs_udr = 1'b1; vs_uir = 1'b0; ir_in = '0; sr = '0;
        cmd_ready = 1'b0; overflow_clr = 1'b0;
        repeat (3) tick();
        check("rst_jdo", jdo, 0);
        check("rst_ir_latched", ir_latched, 0);
        check("rst_take_action", take_action, 0);
        check("rst_ir_update", ir_update, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_ir", cmd_ir, 0);
        check("rst_cmd_data", cmd_data, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);

        // Strobe held high through reset release must not produce an event.
        reset = 1'b0;
        ta_seen = '0; iu_seen = 1'b0; cnt_seen = '0;
        repeat (20) begin
            tick();
            ta_seen  = ta_seen | take_action;
            iu_seen  = iu_seen | ir_update;
            cnt_seen = cnt_seen | fifo_count;
        end
        check("held_take_action", ta_seen, 0);
        check("held_ir_update", iu_seen, 0);
        check("held_fifo_count", cnt_seen, 0);
        vs_udr = 1'b0;
        repeat (4) tick();

        // Single DR update: latency and one-hot decode.
        ir_in = 2'b10; sr = 38'h2A_5555_AAAA; vs_udr = 1'b1;
        tick();                                       // edge k
        tick();                                       // edge k+1
        check("lat_ta_early", take_action, 0);
        tick();                                       // edge k+2
        check("lat_jdo", jdo, 38'h2A_5555_AAAA);
        check("lat_take_action", take_action, 4'b0100);
        check("lat_ir_latched", ir_latched, 2'b10);
        check("lat_valid_early", cmd_valid, 0);
        tick();                                       // edge k+3
        check("lat_ta_width", take_action, 0);
        check("lat_cmd_valid", cmd_valid, 1);
        check("lat_cmd_ir", cmd_ir, 2);
        check("lat_cmd_data", cmd_data, 38'h2A_5555_AAAA);
        check("lat_fifo_count", fifo_count, 1);
        repeat (3) tick();
        check("lat_one_event", fifo_count, 1);
        check("lat_ta_held", take_action, 0);
        vs_udr = 1'b0;
        repeat (4) tick();
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("pop_count", fifo_count, 0);
        check("pop_valid", cmd_valid, 0);

        // Overflow: five commands into a four-deep queue.
        for (int i = 1; i <= 5; i++) udr_event(2'b00, 38'(i));
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_jdo", jdo, 5);

        // Clear coinciding with another drop: set wins, then clear alone works.
        strobe_start(1'b1, 1'b0, 2'b00, 38'd6);
        overflow_clr = 1'b1;
        tick();                                       // drop edge
        check("ovf_set_wins", overflow, 1);
        check("ovf_drop_count", fifo_count, 4);
        tick();
        check("ovf_clr", overflow, 0);
        overflow_clr = 1'b0;
        strobe_end();
        check("ovf_jdo6", jdo, 6);
        for (int i = 1; i <= 4; i++) drain_check("drain1", 38'(i));
        check("drain1_empty", fifo_count, 0);

        // Full queue, push coinciding with pop: accepted, no overflow.
        for (int i = 11; i <= 14; i++) udr_event(2'b11, 38'(i));
        check("fp_full", fifo_count, 4);
        strobe_start(1'b1, 1'b0, 2'b11, 38'd15);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("fp_count", fifo_count, 4);
        check("fp_overflow", overflow, 0);
        strobe_end();
        for (int i = 12; i <= 15; i++) drain_check("drain2", 38'(i));
        check("drain2_empty", fifo_count, 0);

        // DR and IR updates together share the same ir_in sample.
        strobe_start(1'b1, 1'b1, 2'b01, 38'h123);
        check("both_ir_update", ir_update, 1);
        check("both_take_action", take_action, 4'b0010);
        check("both_ir_latched", ir_latched, 2'b01);
        tick();
        check("both_iu_width", ir_update, 0);
        check("both_count", fifo_count, 1);
        check("both_cmd_ir", cmd_ir, 2'b01);
        strobe_end();

        // IR update alone: no push, jdo unchanged.
        strobe_start(1'b0, 1'b1, 2'b11, 38'h3F_FFFF_FFFF);
        check("uir_ir_update", ir_update, 1);
        check("uir_take_action", take_action, 0);
        check("uir_ir_latched", ir_latched, 2'b11);
        check("uir_jdo", jdo, 38'h123);
        tick();
        check("uir_count", fifo_count, 1);
        strobe_end();

        // Reset mid-operation flushes the queue; bridge works again once re-armed.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_valid", cmd_valid, 0);
        check("mid_rst_jdo", jdo, 0);
        repeat (5) tick();
        udr_event(2'b00, 38'h0B_CDEF_0123);
        check("post_rst_jdo", jdo, 38'h0B_CDEF_0123);
        check("post_rst_count", fifo_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
